// File: rtl/nibble_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_pkg
// Purpose  : Shared constants, FSM state type and index-width helper for the
//            nibble-serial adder.
// Revision : 1.0  initial release
// ============================================================================
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ADD  = 1'b1
  } state_t;

  // Width of the nibble index counter; never narrower than one bit.
  function automatic int idx_width(input int nibbles);
    if (nibbles <= 1) return 1;
    return $clog2(nibbles);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_adder
// Purpose  : Combinational 4-bit adder with carry-in; 5-bit result whose MSB
//            is the carry-out. The single adder shared by the serial datapath.
// Revision : 1.0  initial release
// ============================================================================
module nibble_adder
  import nibble_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W:0]   s
);

  // Zero-extend everything to the result width so the carry lands in s[4].
  assign s = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : Adds two NIBBLES-nibble operands through one shared 4-bit adder,
//            one nibble per clock, LS nibble first, with start/busy/done
//            handshake and a registered (W+1)-bit result.
// Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES:0]   sum
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] c_last_idx = IW'(NIBBLES - 1);

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic            r_busy;
  logic            r_done;
  logic [W:0]      r_sum;

  logic [NIBBLE_W:0] w_s;
  logic [W-1:0]      w_acc_next;
  logic              w_last;

  // The one and only adder: current low nibbles plus the running carry.
  nibble_adder u_adder (
    .a   (r_a[NIBBLE_W-1:0]),
    .b   (r_b[NIBBLE_W-1:0]),
    .cin (r_carry),
    .s   (w_s)
  );

  // New nibble enters at the top while older nibbles move down; after
  // NIBBLES steps the first nibble computed sits in the lowest position.
  // Written as shift-and-OR so the NIBBLES=1 case needs no special slice.
  assign w_acc_next = (r_acc >> NIBBLE_W) | (W'(w_s[NIBBLE_W-1:0]) << (W - NIBBLE_W));
  assign w_last     = (r_idx == c_last_idx);

  // Sequencer: capture on start, one nibble per ADD cycle, publish on last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          // start is deliberately not looked at here: no queuing, no recapture.
          r_acc   <= w_acc_next;
          r_carry <= w_s[NIBBLE_W];
          r_a     <= r_a >> NIBBLE_W;
          r_b     <= r_b >> NIBBLE_W;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_sum   <= {w_s[NIBBLE_W], w_acc_next};
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Self-checking bench for nibble_serial_adder (NIBBLES=4 and 1).
// Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4;
  logic [15:0] a4, b4;
  logic        busy4, done4;
  logic [16:0] sum4;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        busy1, done1;
  logic [4:0]  sum1;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] s;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] s;
  } vec1_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  logic [16:0] exp_q[$];
  logic [16:0] last_sum = '0;
  logic [16:0] exp_front;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (rst === 1'b0 && done4 === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_front = exp_q.pop_front();
        check("sum", {15'd0, sum4}, {15'd0, exp_front});
        last_sum = exp_front;
      end
    end
  end

  // One NIBBLES=4 operation; called at a negedge, returns at the done negedge.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
    a4 = a; b4 = b; start4 = 1'b1;
    exp_q.push_back(s);
    @(posedge clk);
    #1 start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("busy_during_add", {31'd0, busy4}, 32'd1);
      check("done_during_add", {31'd0, done4}, 32'd0);
      check("sum_held", {15'd0, sum4}, {15'd0, last_sum});
    end
    @(negedge clk);
    check("busy_at_done", {31'd0, busy4}, 32'd0);
    check("done_pulse", {31'd0, done4}, 32'd1);
  endtask

  vec_t  vecs[8];
  vec1_t vecs1[3];
  vec_t  b2b[3];
  int    dc0;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 17'h10000};
    vecs[1] = '{16'h1234, 16'h4321, 17'h05555};
    vecs[2] = '{16'h0000, 16'h0000, 17'h00000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
    vecs[4] = '{16'h8000, 16'h8000, 17'h10000};
    vecs[5] = '{16'h0F0F, 16'h00F1, 17'h01000};
    vecs[6] = '{16'hABCD, 16'h1111, 17'h0BCDE};
    vecs[7] = '{16'h7FFF, 16'h0001, 17'h08000};
    vecs1[0] = '{4'hF, 4'hF, 5'h1E};
    vecs1[1] = '{4'h8, 4'h7, 5'h0F};
    vecs1[2] = '{4'h0, 4'h1, 5'h01};
    b2b[0] = '{16'h1111, 16'h2222, 17'h03333};
    b2b[1] = '{16'hF000, 16'h1000, 17'h10000};
    b2b[2] = '{16'h00FF, 16'h0001, 17'h00100};

    rst = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;

    // Reset state
    @(negedge clk);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_done4", {31'd0, done4}, 32'd0);
    check("rst_sum4",  {15'd0, sum4},  32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_sum1",  {27'd0, sum1},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven operations
    for (int i = 0; i < 8; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].s);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done4}, 32'd0);
    end

    // start re-asserted mid-operation must be ignored
    dc0 = done_cnt;
    a4 = 16'h0001; b4 = 16'h0001; start4 = 1'b1;
    exp_q.push_back(17'h00002);
    @(posedge clk);
    #1 a4 = 16'hAAAA; b4 = 16'h5555;
    @(posedge clk);
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (3) @(negedge clk);
    check("ign_done_pulse", {31'd0, done4}, 32'd1);
    repeat (6) @(negedge clk);
    check("ign_done_count", done_cnt - dc0, 32'd1);

    // Reset two cycles into an operation aborts it immediately
    a4 = 16'h1234; b4 = 16'h0001; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy4}, 32'd0);
    check("abort_done", {31'd0, done4}, 32'd0);
    check("abort_sum",  {15'd0, sum4},  32'd0);
    last_sum = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_resume", {31'd0, busy4}, 32'd0);
    op4(16'h8000, 16'h8000, 17'h10000);
    @(negedge clk);

    // Back-to-back with start held high; next operands appear on done cycle
    a4 = b2b[0].a; b4 = b2b[0].b; start4 = 1'b1;
    exp_q.push_back(b2b[0].s);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("b2b_busy", {31'd0, busy4}, 32'd1);
        check("b2b_no_done", {31'd0, done4}, 32'd0);
      end
      @(negedge clk);
      check("b2b_done", {31'd0, done4}, 32'd1);
      if (i < 2) begin
        a4 = b2b[i+1].a; b4 = b2b[i+1].b;
        exp_q.push_back(b2b[i+1].s);
      end else begin
        start4 = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle", {31'd0, busy4}, 32'd0);

    // Minimum width: single ADD cycle
    for (int i = 0; i < 3; i++) begin
      a1 = vecs1[i].a; b1 = vecs1[i].b; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      check("n1_busy", {31'd0, busy1}, 32'd1);
      check("n1_no_done", {31'd0, done1}, 32'd0);
      @(negedge clk);
      check("n1_done", {31'd0, done1}, 32'd1);
      check("n1_busy_low", {31'd0, busy1}, 32'd0);
      check("n1_sum", {27'd0, sum1}, {27'd0, vecs1[i].s});
      @(negedge clk);
      check("n1_done_clear", {31'd0, done1}, 32'd0);
    end

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
